// File: rtl/axis_width_downsizer.sv
// axis_width_downsizer
// Splits each S_WIDTH-bit AXI-Stream word into RATIO = S_WIDTH/M_WIDTH narrow
// beats, one beat per cycle. The next word is accepted in the cycle its
// predecessor's last beat leaves, so a continuous stream has no bubbles.
// word_cnt counts words whose final beat has been accepted downstream.

module axis_width_downsizer #(
    parameter int S_WIDTH   = 32,
    parameter int M_WIDTH   = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [S_WIDTH-1:0]   s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [M_WIDTH-1:0]   m_axis_tdata,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int RATIO = S_WIDTH / M_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] RATIO_M1 = IDX_W'(RATIO - 1);

    // Two-state control: IDLE waits for a word, SEND drains the hold register.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    if ((S_WIDTH % M_WIDTH) != 0 || RATIO < 2) begin : g_param_check
        $error("axis_width_downsizer: S_WIDTH must be a multiple of M_WIDTH with RATIO >= 2");
    end

    logic [0:0]           r_state;
    logic                 r_rdy_en;
    logic [IDX_W-1:0]     r_idx;
    logic [S_WIDTH-1:0]   r_data_q;
    logic [CNT_WIDTH-1:0] r_word_cnt;

    logic                 w_busy;
    logic                 w_last;
    logic                 w_s_hs;
    logic                 w_m_hs;
    logic [IDX_W-1:0]     w_sel;

    assign w_busy = (r_state == ST_SEND);
    assign w_last = (r_idx == RATIO_M1);

    // Accept a new word when idle, or when the last beat of the current word
    // is leaving this very cycle (keeps the stream gap-free).
    assign s_axis_tready = r_rdy_en && (!w_busy || (m_axis_tready && w_last));
    assign w_s_hs        = s_axis_tvalid && s_axis_tready;
    assign w_m_hs        = w_busy && m_axis_tready;

    // Slice selection: ascending index for LSB-first, mirrored for MSB-first.
    always_comb begin
        w_sel = r_idx;
        if (MSB_FIRST != 0) begin
            w_sel = RATIO_M1 - r_idx;
        end else begin
            w_sel = r_idx;
        end
    end

    assign m_axis_tvalid = w_busy;
    assign m_axis_tdata  = r_data_q[w_sel*M_WIDTH +: M_WIDTH];
    assign word_cnt      = r_word_cnt;

    // Control and data path: load on input handshake, step on output handshake.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state    <= ST_IDLE;
            r_rdy_en   <= 1'b0;
            r_idx      <= '0;
            r_data_q   <= '0;
            r_word_cnt <= '0;
        end else begin
            r_rdy_en <= 1'b1;

            if (w_s_hs) begin
                r_data_q <= s_axis_tdata;
                r_idx    <= '0;
                r_state  <= ST_SEND;
            end else if (w_m_hs) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end else begin
                r_state <= r_state;
            end

            if (w_m_hs && w_last) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end else begin
                r_word_cnt <= r_word_cnt;
            end
        end
    end

endmodule
